// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream merge block: arbiter FSM states and
// the helper that sizes grant-index buses.
package axis_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = ST_IDLE,
    LOCKED = ST_LOCKED
  } state_t;

  // A single-port build still needs a 1-bit index bus.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational request arbiter. Round-robin from last_grant+1 by default;
// `define AXIS_MULTI_SLAVE_PRIORITY_EN selects fixed lowest-index priority.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter  int PORT_NB  = 8,
  localparam int ID_WIDTH = grant_width(PORT_NB)
) (
  input  logic [PORT_NB-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [PORT_NB-1:0]  grant_oh,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                any_req
);

  logic [ID_WIDTH-1:0] cand;

`ifdef AXIS_MULTI_SLAVE_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  // Candidates are visited from lowest to highest precedence so the final
  // matching write is the winner; no early exit is needed.
  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise the
    // no-request path would leave them unassigned and infer latches.
    grant_oh  = '0;
    grant_idx = '0;
    cand      = '0;
    any_req   = |req;
    for (int k = PORT_NB; k >= 1; k--) begin
`ifdef AXIS_MULTI_SLAVE_PRIORITY_EN
      cand = ID_WIDTH'(k - 1);
`else
      cand = ID_WIDTH'((int'(last_grant) + k) % PORT_NB);
`endif
      if (req[cand]) begin
        grant_oh       = '0;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/axis_multi_slave.sv
// Packet-aware N:1 AXI-Stream merge: a granted input owns the output until
// its tlast beat transfers. Optional macro: AXIS_MULTI_SLAVE_PRIORITY_EN.
module axis_multi_slave
  import axis_pkg::*;
#(
  parameter  int AXIS_DWIDTH = 32,
  parameter  int PORT_NB     = 8,
  localparam int ID_WIDTH    = grant_width(PORT_NB)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NB*AXIS_DWIDTH-1:0] s_tdata,
  input  logic [PORT_NB-1:0]             s_tlast,
  input  logic [PORT_NB-1:0]             s_tvalid,
  output logic [PORT_NB-1:0]             s_tready,
  output logic [AXIS_DWIDTH-1:0]         m_tdata,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [ID_WIDTH-1:0]            m_tid
);

  state_t              state;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] last_grant;

  logic [PORT_NB-1:0]  unused_arb_oh;
  logic [ID_WIDTH-1:0] arb_idx;
  logic                arb_any;

  logic [AXIS_DWIDTH-1:0] port_data [PORT_NB];
  logic                   locked;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   pkt_end;

  for (genvar i = 0; i < PORT_NB; i++) begin : g_port_data
    assign port_data[i] = s_tdata[i*AXIS_DWIDTH +: AXIS_DWIDTH];
  end

  axis_rr_arbiter #(
    .PORT_NB (PORT_NB)
  ) u_arb (
    .req        (s_tvalid),
    .last_grant (last_grant),
    .grant_oh   (unused_arb_oh),
    .grant_idx  (arb_idx),
    .any_req    (arb_any)
  );

  assign locked    = (state == LOCKED);
  assign sel_valid = s_tvalid[grant];
  assign sel_last  = s_tlast[grant];
  assign pkt_end   = locked & sel_valid & sel_last & m_tready;

  // Reset starts last_grant at the top port so port 0 wins the first round.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= ID_WIDTH'(PORT_NB - 1);
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant <= arb_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (pkt_end) begin
`ifndef AXIS_MULTI_SLAVE_PRIORITY_EN
            last_grant <= grant;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency pass-through of the owning port; everything quiet in IDLE.
  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tid    = '0;
    s_tready = '0;
    if (locked) begin
      m_tvalid        = sel_valid;
      m_tlast         = sel_valid & sel_last;
      m_tdata         = port_data[grant];
      m_tid           = grant;
      s_tready[grant] = m_tready;
    end
  end

endmodule

// File: tb/tb_axis_multi_slave.sv
// Self-checking bench for axis_multi_slave (PORT_NB=4): vector table, directed
// corner sequences and random traffic against a packet-level reference model.
`timescale 1ns/100ps
module tb_axis_multi_slave;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef AXIS_MULTI_SLAVE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tready;
  logic [W-1:0]   m_tdata;
  logic           m_tlast;
  logic           m_tvalid;
  logic           m_tready;
  logic [IDW-1:0] m_tid;

  axis_multi_slave #(
    .AXIS_DWIDTH (W),
    .PORT_NB     (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tid    (m_tid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which port currently owns the output (-1 = none) and
  // which port completed the most recent packet.
  int           owner;
  int           rr_last;
  logic [N-1:0] xfer;

  typedef struct packed {
    logic [N-1:0]   vld;
    logic [N-1:0]   lst;
    logic [W-1:0]   d1;
    logic [W-1:0]   d3;
    logic           rdy;
    logic           e_vld;
    logic           e_lst;
    logic [W-1:0]   e_data;
    logic [IDW-1:0] e_id;
    logic [N-1:0]   e_rdy;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int p;
      p = PRIO ? (k - 1) : (rr_last + k) % N;
      if (s_tvalid[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner   = -1;
    rr_last = N - 1;
    xfer    = '0;
  endtask

  task automatic model_check();
    logic         e_vld;
    logic         e_lst;
    logic [N-1:0] e_rdy;
    logic [W-1:0] e_data;
    int           e_id;
    e_vld  = 1'b0;
    e_lst  = 1'b0;
    e_rdy  = '0;
    e_data = '0;
    e_id   = 0;
    if (owner >= 0) begin
      e_vld        = s_tvalid[owner];
      e_lst        = s_tvalid[owner] & s_tlast[owner];
      e_rdy[owner] = m_tready;
      e_data       = s_tdata[owner*W +: W];
      e_id         = owner;
    end
    check("model_m_tvalid", 64'(m_tvalid), 64'(e_vld));
    check("model_m_tlast",  64'(m_tlast),  64'(e_lst));
    check("model_s_tready", 64'(s_tready), 64'(e_rdy));
    check("model_m_tid",    64'(m_tid),    64'(e_id));
    check("model_m_tdata",  64'(m_tdata),  64'(e_data));
  endtask

  task automatic model_update();
    xfer = '0;
    if (owner < 0) begin
      owner = rr_pick();
    end else if (s_tvalid[owner] && m_tready) begin
      xfer[owner] = 1'b1;
      if (s_tlast[owner]) begin
        if (!PRIO) rr_last = owner;
        owner = -1;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic l, input logic [W-1:0] d);
    s_tvalid[p]       = v;
    s_tlast[p]        = l;
    s_tdata[p*W +: W] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    model_reset();

    // Reset with every port requesting single-beat packets.
    s_tvalid = '1;
    s_tlast  = '1;
    for (int p = 0; p < N; p++) s_tdata[p*W +: W] = 32'h10 + 32'(p);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_m_tvalid", 64'(m_tvalid), 64'h0);
    check("reset_m_tlast",  64'(m_tlast),  64'h0);
    check("reset_s_tready", 64'(s_tready), 64'h0);
    check("reset_m_tid",    64'(m_tid),    64'h0);
    check("reset_m_tdata",  64'(m_tdata),  64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fairness: a beat every second cycle, grants rotate 0,1,2,3,0,...
    for (int k = 0; k < 12; k++) begin
      at_neg();
      check("fair_m_tvalid", 64'(m_tvalid), 64'(k % 2));
      if (k % 2 == 1) begin
        check("fair_m_tid",   64'(m_tid),   64'(PRIO ? 0 : ((k - 1) / 2) % N));
        check("fair_m_tdata", 64'(m_tdata), 64'(32'h10 + 32'(PRIO ? 0 : ((k - 1) / 2) % N)));
      end
      at_pos();
    end

    // Round-robin table: ports 1 and 3 each send a 3-beat packet.
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    do_reset();
    vecs[0] = '{4'b1010, 4'b0000, 32'hA0, 32'hC0, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 4'b0000};
    vecs[1] = '{4'b1010, 4'b0000, 32'hA0, 32'hC0, 1'b1, 1'b1, 1'b0, 32'hA0, 2'd1, 4'b0010};
    vecs[2] = '{4'b1010, 4'b0000, 32'hA1, 32'hC0, 1'b1, 1'b1, 1'b0, 32'hA1, 2'd1, 4'b0010};
    vecs[3] = '{4'b1010, 4'b0010, 32'hA2, 32'hC0, 1'b1, 1'b1, 1'b1, 32'hA2, 2'd1, 4'b0010};
    vecs[4] = '{4'b1000, 4'b0000, 32'h00, 32'hC0, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 4'b0000};
    vecs[5] = '{4'b1000, 4'b0000, 32'h00, 32'hC0, 1'b1, 1'b1, 1'b0, 32'hC0, 2'd3, 4'b1000};
    vecs[6] = '{4'b1000, 4'b0000, 32'h00, 32'hC1, 1'b1, 1'b1, 1'b0, 32'hC1, 2'd3, 4'b1000};
    vecs[7] = '{4'b1000, 4'b1000, 32'h00, 32'hC2, 1'b1, 1'b1, 1'b1, 32'hC2, 2'd3, 4'b1000};
    vecs[8] = '{4'b0000, 4'b0000, 32'h00, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      s_tvalid          = vecs[i].vld;
      s_tlast           = vecs[i].lst;
      m_tready          = vecs[i].rdy;
      s_tdata           = '0;
      s_tdata[1*W +: W] = vecs[i].d1;
      s_tdata[3*W +: W] = vecs[i].d3;
      @(negedge clk);
      check($sformatf("tbl%0d_m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].e_vld));
      check($sformatf("tbl%0d_m_tlast",  i), 64'(m_tlast),  64'(vecs[i].e_lst));
      check($sformatf("tbl%0d_m_tdata",  i), 64'(m_tdata),  64'(vecs[i].e_data));
      check($sformatf("tbl%0d_m_tid",    i), 64'(m_tid),    64'(vecs[i].e_id));
      check($sformatf("tbl%0d_s_tready", i), 64'(s_tready), 64'(vecs[i].e_rdy));
      at_pos();
    end

    // Lock and backpressure: port 2 owns the output, port 0 waits.
    m_tready = 1'b1;
    set_port(2, 1'b1, 1'b0, 32'hD0);
    at_neg();
    at_pos();
    at_neg();
    check("bp_beat0_data", 64'(m_tdata), 64'hD0);
    at_pos();
    set_port(2, 1'b1, 1'b0, 32'hD1);
    set_port(0, 1'b1, 1'b1, 32'hE0);
    m_tready = 1'b0;
    at_neg();
    check("bp_stall1_data",   64'(m_tdata),     64'hD1);
    check("bp_stall1_p0_rdy", 64'(s_tready[0]), 64'h0);
    at_pos();
    at_neg();
    check("bp_stall2_data",  64'(m_tdata),  64'hD1);
    check("bp_stall2_valid", 64'(m_tvalid), 64'h1);
    at_pos();
    m_tready = 1'b1;
    at_neg();
    check("bp_resume_s_tready", 64'(s_tready), 64'h4);
    at_pos();
    set_port(2, 1'b1, 1'b0, 32'hD2);
    at_neg();
    check("bp_beat2_p0_rdy", 64'(s_tready[0]), 64'h0);
    at_pos();
    set_port(2, 1'b1, 1'b1, 32'hD3);
    at_neg();
    check("bp_last_m_tlast",  64'(m_tlast),  64'h1);
    check("bp_last_s_tready", 64'(s_tready), 64'h4);
    at_pos();
    set_port(2, 1'b0, 1'b0, 32'h0);
    at_neg();
    check("bp_bubble_m_tvalid", 64'(m_tvalid), 64'h0);
    at_pos();
    at_neg();
    check("bp_p0_m_tid",   64'(m_tid),   64'h0);
    check("bp_p0_m_tdata", 64'(m_tdata), 64'hE0);
    at_pos();
    set_port(0, 1'b0, 1'b0, 32'h0);
    at_neg();
    at_pos();

    // Asynchronous reset during beat 2 of a 4-beat packet from port 1.
    set_port(1, 1'b1, 1'b0, 32'hB0);
    at_neg();
    at_pos();
    at_neg();
    at_pos();
    set_port(1, 1'b1, 1'b0, 32'hB1);
    at_neg();
    at_pos();
    set_port(1, 1'b1, 1'b0, 32'hB2);
    #1;
    check("arst_pre_m_tvalid", 64'(m_tvalid), 64'h1);
    rst = 1'b1;
    #1;
    check("arst_m_tvalid", 64'(m_tvalid), 64'h0);
    check("arst_s_tready", 64'(s_tready), 64'h0);
    check("arst_m_tid",    64'(m_tid),    64'h0);
    check("arst_m_tlast",  64'(m_tlast),  64'h0);
    model_reset();
    #1;
    rst = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'hF0);
    at_neg();
    at_pos();
    at_neg();
    check("arst_regrant_m_tid",    64'(m_tid),    64'h0);
    check("arst_regrant_m_tvalid", 64'(m_tvalid), 64'h1);
    at_pos();

`ifdef AXIS_MULTI_SLAVE_PRIORITY_EN
    // Fixed priority: port 0 wins every packet against port 2.
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    do_reset();
    set_port(0, 1'b1, 1'b1, 32'h50);
    set_port(2, 1'b1, 1'b1, 32'h52);
    for (int k = 0; k < 8; k++) begin
      at_neg();
      if (m_tvalid) check("prio_m_tid", 64'(m_tid), 64'h0);
      at_pos();
    end
`endif

    // Random AXIS-compliant sources and consumer against the model.
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      at_neg();
      at_pos();
      for (int p = 0; p < N; p++) begin
        if (!s_tvalid[p] || xfer[p]) begin
          if ($urandom_range(9) < 6) set_port(p, 1'b1, ($urandom_range(3) == 0), $urandom());
          else                       set_port(p, 1'b0, 1'b0, 32'h0);
        end
      end
      m_tready = ($urandom_range(3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
